// File: rtl/keccak_load_stage.sv
// SHA-3/SHAKE input stage: takes a header plus a word-stream message and
// emits rate-sized, suffix- and pad10*1-padded blocks over valid/ready.
module keccak_load_stage #(
  parameter int W        = 64,
  parameter int MAX_RATE = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [MAX_RATE-1:0] blk_data,
  output logic                blk_last,
  output logic [2:0]          mode,
  output logic [27:0]         out_size,
  output logic                hdr_err
);
  localparam int unsigned BPW = W / 8;
  localparam int NW = MAX_RATE / W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {HDR0, HDR1, ABSORB, PAD, EMIT} state_t;
  localparam state_t HDR_FIRST = (W == 32) ? HDR0 : HDR1;

  state_t              state, state_nxt;
  logic [31:0]         rem_bytes;
  logic [IW-1:0]       widx, last_idx;
  logic [MAX_RATE-1:0] blk_buf;
  logic                sfx_done, last_blk;
  logic [2:0]          mode_r;
  logic [27:0]         out_size_r;
  logic                hdr_err_r;
  logic [W-1:0]        word;
  logic                sfx_here;
  logic [7:0]          sfx;
  logic                accept, wr, hs, msg_end, len_zero;

  function automatic logic [10:0] rate_bits(input logic [2:0] m);
    case (m)
      3'd0:    rate_bits = 11'd1152;
      3'd1:    rate_bits = 11'd1088;
      3'd2:    rate_bits = 11'd832;
      3'd3:    rate_bits = 11'd576;
      3'd5:    rate_bits = 11'd1088;
      default: rate_bits = 11'd1344;
    endcase
  endfunction

  assign last_idx = IW'(32'(rate_bits(mode_r)) / 32'(W) - 32'd1);
  assign sfx      = (mode_r <= 3'd3) ? 8'h06 : 8'h1F;
  assign accept   = in_valid && in_ready;
  assign hs       = blk_valid && blk_ready;
  assign wr       = (state == ABSORB && accept) || (state == PAD);
  assign msg_end  = rem_bytes <= 32'(BPW);
  assign len_zero = (W == 64) ? (in_data[31:3] == '0) : (rem_bytes == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR_FIRST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0:   if (accept) state_nxt = HDR1;
      HDR1:   if (accept) state_nxt = len_zero ? PAD : ABSORB;
      ABSORB: if (accept) begin
        if (widx == last_idx) state_nxt = EMIT;
        else if (msg_end)     state_nxt = PAD;
      end
      PAD:    if (widx == last_idx) state_nxt = EMIT;
      EMIT:   if (blk_ready) begin
        if (last_blk)              state_nxt = HDR_FIRST;
        else if (rem_bytes != '0)  state_nxt = ABSORB;
        else                       state_nxt = PAD;
      end
      default: state_nxt = HDR_FIRST;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    if (!rst) begin
      in_ready  = (state == HDR0) || (state == HDR1) || (state == ABSORB);
      blk_valid = (state == EMIT);
    end
    blk_last = blk_valid && last_blk;
    blk_data = rst ? '0 : blk_buf;
    mode     = rst ? '0 : mode_r;
    out_size = rst ? '0 : out_size_r;
    hdr_err  = rst ? 1'b0 : hdr_err_r;
  end

  // Byte k < rem is message, byte k == rem carries the suffix once; in PAD
  // rem is 0 so the suffix lands in byte 0 if the message ended word-aligned.
  always_comb begin
    word     = '0;
    sfx_here = 1'b0;
    for (int unsigned k = 0; k < BPW; k++) begin
      if (state == ABSORB && k < rem_bytes) begin
        word[8*k +: 8] = in_data[W-1-8*k -: 8];
      end else if (!sfx_done && k == rem_bytes) begin
        word[8*k +: 8] = sfx;
        sfx_here       = 1'b1;
      end
    end
    if (widx == last_idx && (sfx_done || sfx_here))
      word[W-1 -: 8] = word[W-1 -: 8] | 8'h80;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_bytes  <= '0;
      widx       <= '0;
      blk_buf    <= '0;
      sfx_done   <= 1'b0;
      last_blk   <= 1'b0;
      mode_r     <= '0;
      out_size_r <= '0;
      hdr_err_r  <= 1'b0;
    end else begin
      if (accept && ((W == 32 && state == HDR0) || (W == 64 && state == HDR1)))
        rem_bytes <= {3'b000, in_data[31:3]};
      if (accept && state == HDR1) begin
        mode_r     <= in_data[W-1 -: 3];
        out_size_r <= in_data[W-5 -: 28];
        hdr_err_r  <= (in_data[W-1 -: 2] == 2'b11);
        sfx_done   <= 1'b0;
        last_blk   <= 1'b0;
        widx       <= '0;
      end
      if (wr) begin
        blk_buf[widx*W +: W] <= word;
        if (sfx_here) sfx_done <= 1'b1;
        if (widx == last_idx) last_blk <= sfx_done || sfx_here;
        else                  widx <= widx + IW'(1);
        if (state == ABSORB) rem_bytes <= msg_end ? '0 : rem_bytes - 32'(BPW);
      end
      if (hs) begin
        widx    <= '0;
        blk_buf <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_load_stage.sv
// Bench for keccak_load_stage: directed table plus random messages checked
// against a byte-level FIPS 202 padding model, and a W=32 instance.
module tb_keccak_load_stage;
  localparam int MR = 1344;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          in_valid, in_ready, blk_valid, blk_ready, blk_last, hdr_err;
  logic [63:0]   in_data;
  logic [MR-1:0] blk_data;
  logic [2:0]    mode;
  logic [27:0]   out_size;

  logic          in_valid32, in_ready32, blk_valid32, blk_ready32, blk_last32, hdr_err32;
  logic [31:0]   in_data32;
  logic [MR-1:0] blk_data32;
  logic [2:0]    mode32;
  logic [27:0]   out_size32;

  keccak_load_stage #(.W(64), .MAX_RATE(MR)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .mode(mode), .out_size(out_size), .hdr_err(hdr_err));

  keccak_load_stage #(.W(32), .MAX_RATE(MR)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .blk_valid(blk_valid32), .blk_ready(blk_ready32), .blk_data(blk_data32), .blk_last(blk_last32),
    .mode(mode32), .out_size(out_size32), .hdr_err(hdr_err32));

  int n_pass = 0;
  int n_total = 0;
  int rates[8] = '{1152, 1088, 832, 576, 1344, 1088, 1344, 1344};

  typedef struct {
    logic [2:0]  m;
    int unsigned len;
    logic [27:0] osz;
    int unsigned stall;
    logic        err;
    int unsigned nblk;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_blk(input string name, input logic [MR-1:0] act, input logic [MR-1:0] exp);
    int idx;
    idx = -1;
    n_total++;
    for (int k = MR/8 - 1; k >= 0; k--)
      if (act[8*k +: 8] !== exp[8*k +: 8]) idx = k;
    if (idx < 0) n_pass++;
    else $display("FAIL %s: byte %0d got %02h expected %02h", name, idx,
                  act[8*idx +: 8], exp[8*idx +: 8]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_blk_valid"}, blk_valid, 0);
    check({tag, "_blk_last"}, blk_last, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_out_size"}, out_size, 0);
    check({tag, "_hdr_err"}, hdr_err, 0);
    check_blk({tag, "_blk_data"}, blk_data, '0);
    check({tag, "_in_ready32"}, in_ready32, 0);
    check({tag, "_blk_valid32"}, blk_valid32, 0);
  endtask

  // Drives one W=64 message and checks every block against the padding model.
  task automatic run64(input logic [2:0] m, input int unsigned len, input logic [27:0] osz,
                       input int unsigned stall, input logic err, input int unsigned nblk,
                       input bit rnd);
    logic [7:0]    msg[$];
    logic [7:0]    pb[$];
    logic [63:0]   words[$];
    logic [MR-1:0] eblk[$];
    bit            elast[$];
    logic [MR-1:0] blk;
    logic [63:0]   w;
    logic [31:0]   lenv;
    int unsigned   rb, i, got, hold, cyc, nb, nbm;
    bit            hdr_seen;

    rb = rates[m] / 8;
    for (int unsigned k = 0; k < len; k++) msg.push_back(8'($urandom));
    pb = msg;
    pb.push_back((m < 3'd4) ? 8'h06 : 8'h1F);
    while (pb.size() % rb != 0) pb.push_back(8'h00);
    pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
    nbm = pb.size() / rb;
    for (int unsigned b = 0; b < nbm; b++) begin
      blk = '0;
      for (int unsigned k = 0; k < rb; k++) blk[8*k +: 8] = pb[b*rb + k];
      eblk.push_back(blk);
      elast.push_back(b == nbm - 1);
    end
    nb = (nblk == 0) ? nbm : nblk;

    lenv = len;
    words.push_back({m, 1'b0, osz, lenv[28:0], 3'($urandom)});
    for (int unsigned k = 0; k < len; k += 8) begin
      w = '0;
      for (int unsigned j = 0; j < 8; j++)
        w[63-8*j -: 8] = (k + j < len) ? msg[k+j] : 8'($urandom);
      words.push_back(w);
    end

    i = 0; got = 0; hold = 0; cyc = 0; hdr_seen = 0;
    while ((i < words.size() || got < nb) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      blk_ready = 1'b0;
      if (blk_valid) begin
        if (!hdr_seen) begin
          check("mode", mode, m);
          check("out_size", out_size, osz);
          check("hdr_err", hdr_err, err);
          hdr_seen = 1;
        end
        if (got < eblk.size()) begin
          check_blk("blk_data", blk_data, eblk[got]);
          check("blk_last", blk_last, elast[got]);
        end else begin
          check("extra_blk", blk_valid, 0);
        end
        if (hold < stall) begin
          check("in_ready_emit", in_ready, 0);
          hold++;
        end else begin
          blk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (blk_ready) got++;
        end
      end
      if (i < words.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = words[i];
        if (in_ready) i++;
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
      end
    end
    if (cyc >= 5000) check("timeout_blocks", 64'(got), 64'(nb));
    @(negedge clk);
    blk_ready = 1'b0;
    in_valid  = 1'b0;
    check("no_extra_blk", blk_valid, 0);
    check("ready_next_hdr", in_ready, 1);
  endtask

  initial begin
    logic [31:0]   w32[4];
    logic [MR-1:0] rest;
    int unsigned   i, cyc;
    logic [2:0]    rm;

    vecs[0] = '{m: 3'd1, len: 0,   osz: 28'd256,  stall: 0, err: 1'b0, nblk: 1};
    vecs[1] = '{m: 3'd4, len: 168, osz: 28'd1000, stall: 0, err: 1'b0, nblk: 2};
    vecs[2] = '{m: 3'd3, len: 71,  osz: 28'd512,  stall: 0, err: 1'b0, nblk: 1};
    vecs[3] = '{m: 3'd7, len: 10,  osz: 28'd77,   stall: 5, err: 1'b1, nblk: 1};
    vecs[4] = '{m: 3'd2, len: 104, osz: 28'd384,  stall: 0, err: 1'b0, nblk: 2};
    vecs[5] = '{m: 3'd0, len: 200, osz: 28'd224,  stall: 3, err: 1'b0, nblk: 2};
    vecs[6] = '{m: 3'd5, len: 135, osz: 28'd4096, stall: 0, err: 1'b0, nblk: 1};
    vecs[7] = '{m: 3'd6, len: 336, osz: 28'd12,   stall: 0, err: 1'b1, nblk: 3};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; blk_ready32 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    for (int v = 0; v < 8; v++)
      run64(vecs[v].m, vecs[v].len, vecs[v].osz, vecs[v].stall, vecs[v].err, vecs[v].nblk, 0);

    for (int r = 0; r < 24; r++) begin
      rm = 3'($urandom_range(0, 7));
      run64(rm, $urandom_range(0, 400), 28'($urandom), 0, rm >= 3'd6, 0, 1);
    end

    // W=32, SHAKE256, 5-byte message; trailing bytes of word 2 are garbage.
    w32[0] = 32'd45;
    w32[1] = {3'd5, 1'b0, 28'd512};
    w32[2] = 32'h01020304;
    w32[3] = 32'h05AABBCC;
    i = 0; cyc = 0;
    while (i < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      in_valid32 = 1'b1;
      in_data32  = w32[i];
      if (in_ready32) i++;
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    cyc = 0;
    while (!blk_valid32 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("w32_blk_valid", blk_valid32, 1);
    check("w32_lane0", blk_data32[63:0], 64'h00001F0504030201);
    check("w32_byte135", blk_data32[1087:1080], 8'h80);
    rest = blk_data32;
    rest[63:0] = '0;
    rest[1087:1080] = '0;
    check_blk("w32_rest_zero", rest, '0);
    check("w32_blk_last", blk_last32, 1);
    check("w32_out_size", out_size32, 28'd512);
    check("w32_mode", mode32, 3'd5);
    check("w32_hdr_err", hdr_err32, 0);
    blk_ready32 = 1'b1;
    @(negedge clk);
    blk_ready32 = 1'b0;
    check("w32_valid_drop", blk_valid32, 0);
    check("w32_ready_hdr", in_ready32, 1);

    // Reset with ten message words buffered in a SHAKE128 block.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (k == 0) ? {3'd4, 1'b0, 28'd9, 32'd1600} : {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    #1;
    check("ready_after_rst_mid", in_ready, 1);
    run64(3'd4, 20, 28'd33, 0, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
